// File: rtl/i2s_pkg.sv
// Shared I2S definitions: channel codes, receiver FSM encoding and the widest supported word.
package i2s_pkg;

  localparam logic CH_LEFT   = 1'b0;
  localparam logic CH_RIGHT  = 1'b1;
  localparam int   I2S_MAX_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } i2s_state_e;

endpackage

// File: rtl/i2s_sync_edge.sv
// Brings BCLK/LRCK/SDATA into the clkin domain through equal-length chains and
// produces a one-cycle strobe on each synchronized BCLK rising edge.
module i2s_sync_edge #(
  parameter int SYNC_N = 2
) (
  input  logic clkin,
  input  logic i2s_bclk,
  input  logic i2s_lrck,
  input  logic i2s_sdata,
  output logic bclk_rise,
  output logic lrck_s,
  output logic sdata_s
);

  // Lane order inside each stage: [2]=bclk, [1]=lrck, [0]=sdata.
  logic [SYNC_N-1:0][2:0] sync_q, sync_d;
  logic                   bclk_prev_q, bclk_prev_d;

  always_comb begin
    sync_d      = {sync_q[SYNC_N-2:0], i2s_bclk, i2s_lrck, i2s_sdata};
    bclk_prev_d = sync_q[SYNC_N-1][2];
  end

  // Left unreset so the chains already track the pins when reset releases.
  always_ff @(posedge clkin) begin
    sync_q      <= sync_d;
    bclk_prev_q <= bclk_prev_d;
  end

  assign bclk_rise = sync_q[SYNC_N-1][2] & ~bclk_prev_q;
  assign lrck_s    = sync_q[SYNC_N-1][1];
  assign sdata_s   = sync_q[SYNC_N-1][0];

endmodule

// File: rtl/i2s_rx_slave.sv
// I2S slave receiver: deserializes left/right words sampled on BCLK rises and
// presents each complete stereo frame on a valid/ready output register.
module i2s_rx_slave
  import i2s_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SYNC_N = 2
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic              i2s_bclk,
  input  logic              i2s_lrck,
  input  logic              i2s_sdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_left,
  output logic [DATA_W-1:0] out_right,
  output logic              word_err,
  output logic              overrun,
  input  logic              clr_overrun
);

  localparam int CNT_W = $clog2(I2S_MAX_W + 1);

  logic bclk_rise, lrck_s, sdata_s;

  i2s_sync_edge #(.SYNC_N(SYNC_N)) u_sync (
    .clkin     (clkin),
    .i2s_bclk  (i2s_bclk),
    .i2s_lrck  (i2s_lrck),
    .i2s_sdata (i2s_sdata),
    .bclk_rise (bclk_rise),
    .lrck_s    (lrck_s),
    .sdata_s   (sdata_s)
  );

  i2s_state_e        state_q, state_d;
  logic              chan_q, chan_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              have_left_q, have_left_d;
  logic              lr_prev_q, lr_prev_d;
  logic              lr_vld_q, lr_vld_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [DATA_W-1:0] hold_l_q, hold_l_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_left_q, out_left_d;
  logic [DATA_W-1:0] out_right_q, out_right_d;
  logic              word_err_q, word_err_d;
  logic              overrun_q, overrun_d;

  logic              lr_edge;
  logic              frame_done;
  logic              overrun_set;
  logic [DATA_W-1:0] shift_w;

  // lr_vld_q blocks a false edge on the first rise after reset, before lr_prev is known.
  assign lr_edge = bclk_rise & lr_vld_q & (lrck_s != lr_prev_q);
  assign shift_w = {sreg_q[DATA_W-2:0], sdata_s};

  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    cnt_d       = cnt_q;
    have_left_d = have_left_q;
    lr_prev_d   = lr_prev_q;
    lr_vld_d    = lr_vld_q;
    sreg_d      = sreg_q;
    hold_l_d    = hold_l_q;
    word_err_d  = 1'b0;
    frame_done  = 1'b0;

    if (bclk_rise) begin
      lr_prev_d = lrck_s;
      lr_vld_d  = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (lr_edge) begin
          state_d = ST_SHIFT;
          chan_d  = lrck_s;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (lr_edge) begin
          // Short word: drop it and any unpaired left, then start the new channel.
          word_err_d  = 1'b1;
          have_left_d = 1'b0;
          chan_d      = lrck_s;
          cnt_d       = '0;
        end else if (bclk_rise) begin
          sreg_d = shift_w;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = ST_DONE;
            if (chan_q == CH_LEFT) begin
              hold_l_d    = shift_w;
              have_left_d = 1'b1;
            end else if (have_left_q) begin
              frame_done  = 1'b1;
              have_left_d = 1'b0;
            end
          end
        end
      end
      ST_DONE: begin
        if (lr_edge) begin
          state_d = ST_SHIFT;
          chan_d  = lrck_s;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    overrun_set = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (frame_done) begin
      if (!out_valid_q || out_ready) begin
        out_left_d  = hold_l_q;
        out_right_d = shift_w;
        out_valid_d = 1'b1;
      end else begin
        overrun_set = 1'b1;
      end
    end

    overrun_d = overrun_set | (overrun_q & ~clr_overrun);
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      chan_q      <= CH_LEFT;
      cnt_q       <= '0;
      have_left_q <= 1'b0;
      lr_prev_q   <= 1'b0;
      lr_vld_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_left_q  <= '0;
      out_right_q <= '0;
      word_err_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      cnt_q       <= cnt_d;
      have_left_q <= have_left_d;
      lr_prev_q   <= lr_prev_d;
      lr_vld_q    <= lr_vld_d;
      out_valid_q <= out_valid_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      word_err_q  <= word_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_ff @(posedge clkin) begin
    sreg_q   <= sreg_d;
    hold_l_q <= hold_l_d;
  end

  assign out_valid = out_valid_q;
  assign out_left  = out_left_q;
  assign out_right = out_right_q;
  assign word_err  = word_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_i2s_rx_slave.sv
// Drives an I2S transmitter model (BCLK = clkin/16, 32-bit slots) into i2s_rx_slave and
// scores delivered frames against a queue of expected left/right pairs.
module tb_i2s_rx_slave;

  localparam int DATA_W = 16;
  localparam int SYNC_N = 2;

  logic              clk;
  logic              reset;
  logic              i2s_bclk, i2s_lrck, i2s_sdata;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_left, out_right;
  logic              word_err, overrun, clr_overrun;

  i2s_rx_slave #(.DATA_W(DATA_W), .SYNC_N(SYNC_N)) dut (
    .clkin       (clk),
    .reset       (reset),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrck    (i2s_lrck),
    .i2s_sdata   (i2s_sdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_left    (out_left),
    .out_right   (out_right),
    .word_err    (word_err),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
  } frame_t;

  frame_t exp_q[$];
  frame_t mon_f;
  int     xfer_cnt = 0;
  int     werr_cnt = 0;
  logic   tog_en   = 1'b0;

  always @(negedge clk) begin
    if (word_err) werr_cnt++;
    if (out_valid && out_ready) begin
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 32'd1, 32'd0);
      end else begin
        mon_f = exp_q.pop_front();
        check("out_left", 32'(out_left), 32'(mon_f.l));
        check("out_right", 32'(out_right), 32'(mon_f.r));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (tog_en) out_ready = ~out_ready;
    end
  end

  task automatic set_ready(input logic v);
    @(posedge clk);
    #2 out_ready = v;
  endtask

  // One bit period: data/word-select change while BCLK is low, sampled on the rise.
  task automatic send_bit(input logic lr, input logic d);
    i2s_lrck  = lr;
    i2s_sdata = d;
    #40 i2s_bclk = 1'b1;
    #80 i2s_bclk = 1'b0;
    #40;
  endtask

  // Period 0 carries the previous word's LSB slot; MSB goes out in period 1.
  task automatic send_slot(input logic lr, input logic [DATA_W-1:0] w, input int nper);
    for (int p = 0; p < nper; p++) begin
      if (p >= 1 && p <= DATA_W) send_bit(lr, w[DATA_W-p]);
      else                       send_bit(lr, 1'b0);
    end
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                            input bit push);
    frame_t f;
    f.l = l;
    f.r = r;
    if (push) exp_q.push_back(f);
    send_slot(1'b0, l, 32);
    send_slot(1'b1, r, 32);
  endtask

  initial begin
    reset       = 1'b1;
    i2s_bclk    = 1'b0;
    i2s_lrck    = 1'b0;
    i2s_sdata   = 1'b0;
    out_ready   = 1'b0;
    clr_overrun = 1'b0;
    repeat (4) @(negedge clk);

    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_left", 32'(out_left), 32'd0);
    check("rst_out_right", 32'(out_right), 32'd0);
    check("rst_word_err", 32'(word_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;

    // Basic frame
    set_ready(1'b1);
    send_slot(1'b1, 16'h1234, 32);
    send_frame(16'hA5C3, 16'h3C5A, 1'b1);
    #200;
    check("t1_xfers", 32'(xfer_cnt), 32'd1);
    check("t1_word_err", 32'(werr_cnt), 32'd0);

    // Backpressure and overrun
    set_ready(1'b0);
    send_frame(16'h1111, 16'h2222, 1'b1);
    send_frame(16'h3333, 16'h4444, 1'b0);
    check("t2_overrun_set", 32'(overrun), 32'd1);
    check("t2_hold_left", 32'(out_left), 32'h1111);
    send_frame(16'h5555, 16'h6666, 1'b0);
    check("t2_hold_right", 32'(out_right), 32'h2222);
    check("t2_hold_valid", 32'(out_valid), 32'd1);
    @(negedge clk) clr_overrun = 1'b1;
    @(negedge clk) clr_overrun = 1'b0;
    check("t2_overrun_clr", 32'(overrun), 32'd0);
    set_ready(1'b1);
    repeat (3) @(negedge clk);
    check("t2_xfers", 32'(xfer_cnt), 32'd2);
    check("t2_valid_drop", 32'(out_valid), 32'd0);

    // Reset released mid right slot
    reset = 1'b1;
    for (int p = 0; p < 10; p++) send_bit(1'b1, 1'($urandom_range(1)));
    reset = 1'b0;
    for (int p = 10; p < 32; p++) send_bit(1'b1, 1'($urandom_range(1)));
    send_frame(16'h0001, 16'h8000, 1'b1);
    #200;
    check("t3_xfers", 32'(xfer_cnt), 32'd3);
    check("t3_word_err", 32'(werr_cnt), 32'd0);

    // Short left slot
    send_slot(1'b0, 16'h1357, 10);
    send_slot(1'b1, 16'h2468, 32);
    check("t4_word_err", 32'(werr_cnt), 32'd1);
    check("t4_no_frame", 32'(xfer_cnt), 32'd3);
    send_frame(16'h4321, 16'h8765, 1'b1);
    #200;
    check("t4_xfers", 32'(xfer_cnt), 32'd4);

    // One-cycle reset inside a right word
    send_slot(1'b0, 16'hBEEF, 32);
    send_bit(1'b1, 1'b0);
    for (int p = 1; p < 8; p++) send_bit(1'b1, 1'b1);
    #10 reset = 1'b1;
    #10 reset = 1'b0;
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_out_left", 32'(out_left), 32'd0);
    check("t5_out_right", 32'(out_right), 32'd0);
    check("t5_overrun", 32'(overrun), 32'd0);
    for (int p = 8; p < 32; p++) send_bit(1'b1, 1'b1);
    send_frame(16'h7FFF, 16'h8001, 1'b1);
    #200;
    check("t5_xfers", 32'(xfer_cnt), 32'd5);

    // Toggling ready, back-to-back frames
    tog_en = 1'b1;
    for (int i = 0; i < 20; i++) send_frame(16'(16'h0100 + i), 16'(16'hF000 + i), 1'b1);
    #400;
    tog_en = 1'b0;
    set_ready(1'b1);
    repeat (4) @(negedge clk);
    check("t6_xfers", 32'(xfer_cnt), 32'd25);
    check("t6_overrun", 32'(overrun), 32'd0);
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t6_word_err", 32'(werr_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
